// File: rtl/banco_registradores_param_if.sv
// Register-file bus: read/write ports plus the debug snapshot stream.
// Master drives requests and consumes data; slave is the register bank.
interface banco_registradores_param_if #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned AW      = 5,
   parameter int unsigned STATE_W = 4
);
   logic [STATE_W-1:0] estado;
   logic [AW-1:0]      rs1;
   logic [AW-1:0]      rs2;
   logic [AW-1:0]      rd;
   logic               regiwrite;
   logic               memtoreg;
   logic [XLEN-1:0]    alu_result;
   logic [XLEN-1:0]    mem_rdata;
   logic [XLEN-1:0]    rdata1;
   logic [XLEN-1:0]    rdata2;
   logic               snap_req;
   logic               snap_busy;
   logic               dbg_valid;
   logic               dbg_ready;
   logic [AW-1:0]      dbg_idx;
   logic [XLEN-1:0]    dbg_data;
   logic               dbg_done;

   modport master (
      output estado, rs1, rs2, rd, regiwrite, memtoreg,
      output alu_result, mem_rdata, snap_req, dbg_ready,
      input  rdata1, rdata2, snap_busy, dbg_valid,
      input  dbg_idx, dbg_data, dbg_done
   );

   modport slave (
      input  estado, rs1, rs2, rd, regiwrite, memtoreg,
      input  alu_result, mem_rdata, snap_req, dbg_ready,
      output rdata1, rdata2, snap_busy, dbg_valid,
      output dbg_idx, dbg_data, dbg_done
   );
endinterface

// File: rtl/banco_registradores_param.sv
// Parametrised RISC-V register file with a handshaked debug snapshot streamer.
// Optional WRITE_BYPASS_EN: same-cycle write data forwarded to the read ports.
module banco_registradores_param #(
   parameter int unsigned        XLEN       = 32,
   parameter int unsigned        AW         = 5,
   parameter int unsigned        STATE_W    = 4,
   parameter logic [STATE_W-1:0] WB_STATE_A = 4'b0110,
   parameter logic [STATE_W-1:0] WB_STATE_B = 4'b0111
) (
   input logic                   clk,
   input logic                   rst,
   banco_registradores_param_if.slave bus
);
   localparam int unsigned NREGS = 1 << AW;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } snap_state_e;

   logic [XLEN-1:0] regs_q [NREGS];
   logic            we;
   logic [XLEN-1:0] wdata;
   logic [XLEN-1:0] rdata1;
   logic [XLEN-1:0] rdata2;

   snap_state_e     state_q;
   logic            busy_q;
   logic            valid_q;
   logic            done_q;
   logic [AW-1:0]   idx_q;
   logic [XLEN-1:0] data_q;

   always_comb begin
      wdata = bus.memtoreg ? bus.mem_rdata : bus.alu_result;
      we    = bus.regiwrite
            && (bus.estado == WB_STATE_A || bus.estado == WB_STATE_B)
            && (bus.rd != '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= '0;
         end
      end else if (we) begin
         regs_q[bus.rd] <= wdata;
      end
   end

   always_comb begin
      rdata1 = (bus.rs1 == '0) ? '0 : regs_q[bus.rs1];
      rdata2 = (bus.rs2 == '0) ? '0 : regs_q[bus.rs2];
`ifdef WRITE_BYPASS_EN
      if (we && bus.rs1 == bus.rd) rdata1 = wdata;
      if (we && bus.rs2 == bus.rd) rdata2 = wdata;
`endif
   end

   // The next beat is loaded from the pre-commit array; a same-edge
   // commit to that index shows up only in a later snapshot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         idx_q   <= '0;
         data_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.snap_req) begin
                  state_q <= SCAN;
                  busy_q  <= 1'b1;
                  valid_q <= 1'b1;
                  idx_q   <= '0;
                  data_q  <= regs_q[0];
               end
            end
            SCAN: begin
               if (valid_q && bus.dbg_ready) begin
                  if (&idx_q) begin
                     state_q <= DONE;
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q  <= idx_q + AW'(1);
                     data_q <= regs_q[idx_q + AW'(1)];
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rdata1    = rdata1;
   assign bus.rdata2    = rdata2;
   assign bus.snap_busy = busy_q;
   assign bus.dbg_valid = valid_q;
   assign bus.dbg_done  = done_q;
   assign bus.dbg_idx   = idx_q;
   assign bus.dbg_data  = data_q;
endmodule

// File: tb/tb_banco_registradores_param.sv
// Bench for banco_registradores_param: directed scenarios plus a randomized
// concurrent write/read/snapshot run against an array-based reference model.
module tb_banco_registradores_param;
   localparam int XLEN  = 32;
   localparam int AW    = 5;
   localparam int NREGS = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [XLEN-1:0] model [NREGS];

   always #5 clk = ~clk;

   banco_registradores_param_if #(.XLEN(XLEN), .AW(AW), .STATE_W(4)) bus_if ();

   banco_registradores_param dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   function automatic logic commit_now();
      return bus_if.regiwrite
          && (bus_if.estado == 4'b0110 || bus_if.estado == 4'b0111)
          && (bus_if.rd != 0);
   endfunction

   function automatic logic [XLEN-1:0] wb_data();
      return bus_if.memtoreg ? bus_if.mem_rdata : bus_if.alu_result;
   endfunction

   function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] rs);
      logic [XLEN-1:0] v;
      v = (rs == 0) ? '0 : model[rs];
`ifdef WRITE_BYPASS_EN
      if (commit_now() && rs == bus_if.rd) v = wb_data();
`endif
      return v;
   endfunction

   // Advance one clock; apply the architectural commit rule to the model.
   task automatic step();
      logic            c;
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      c = commit_now();
      a = bus_if.rd;
      d = wb_data();
      @(posedge clk);
      if (c) model[a] = d;
      #1;
   endtask

   task automatic write_reg(input logic [AW-1:0] r, input logic [XLEN-1:0] v);
      bus_if.rd = r; bus_if.alu_result = v; bus_if.memtoreg = 1'b0;
      bus_if.estado = 4'b0110; bus_if.regiwrite = 1'b1;
      step();
      bus_if.regiwrite = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      #1;
      checks++;
      if (bus_if.snap_busy !== 1'b0 || bus_if.dbg_valid !== 1'b0 ||
          bus_if.dbg_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got busy=%b valid=%b done=%b expected 0 0 0",
                  bus_if.snap_busy, bus_if.dbg_valid, bus_if.dbg_done);
      end
      checks++;
      if (bus_if.dbg_idx !== '0 || bus_if.dbg_data !== '0) begin
         errors++;
         $display("FAIL reset_dbg: got idx=%0d data=%h expected 0 0",
                  bus_if.dbg_idx, bus_if.dbg_data);
      end
      bus_if.rs1 = 5'd17; bus_if.rs2 = 5'd31; #1;
      checks++;
      if (bus_if.rdata1 !== '0 || bus_if.rdata2 !== '0) begin
         errors++;
         $display("FAIL reset_regs: got %h %h expected 0 0",
                  bus_if.rdata1, bus_if.rdata2);
      end
      @(negedge clk);
      rst = 1'b1;
      step();
   endtask

   task automatic test_write_gating();
      bus_if.rs1 = 5'd5; bus_if.rd = 5'd5; bus_if.memtoreg = 1'b0;
      bus_if.alu_result = 32'hDEADBEEF; bus_if.regiwrite = 1'b1;
      bus_if.estado = 4'b0011;
      step();
      bus_if.regiwrite = 1'b0; #1;
      checks++;
      if (bus_if.rdata1 !== 32'h0) begin
         errors++;
         $display("FAIL gate_wrong_state: got %h expected %h", bus_if.rdata1, 32'h0);
      end
      bus_if.regiwrite = 1'b1; bus_if.estado = 4'b0110;
      step();
      bus_if.regiwrite = 1'b0; #1;
      checks++;
      if (bus_if.rdata1 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL gate_state_a: got %h expected %h", bus_if.rdata1, 32'hDEADBEEF);
      end
      bus_if.memtoreg = 1'b1; bus_if.mem_rdata = 32'h12345678;
      bus_if.regiwrite = 1'b1; bus_if.estado = 4'b0111;
      step();
      bus_if.regiwrite = 1'b0; bus_if.memtoreg = 1'b0; #1;
      checks++;
      if (bus_if.rdata1 !== 32'h12345678) begin
         errors++;
         $display("FAIL gate_state_b_mem: got %h expected %h", bus_if.rdata1, 32'h12345678);
      end
   endtask

   task automatic test_x0();
      bus_if.rd = 5'd0; bus_if.rs1 = 5'd0; bus_if.rs2 = 5'd0;
      bus_if.alu_result = 32'hFFFFFFFF; bus_if.memtoreg = 1'b0;
      bus_if.estado = 4'b0110; bus_if.regiwrite = 1'b1; #1;
      checks++;
      if (bus_if.rdata1 !== 32'h0) begin
         errors++;
         $display("FAIL x0_same_cycle: got %h expected 0", bus_if.rdata1);
      end
      step();
      bus_if.regiwrite = 1'b0; #1;
      checks++;
      if (bus_if.rdata1 !== 32'h0 || bus_if.rdata2 !== 32'h0) begin
         errors++;
         $display("FAIL x0_after: got %h %h expected 0 0", bus_if.rdata1, bus_if.rdata2);
      end
   endtask

   task automatic test_bypass();
      logic [XLEN-1:0] exp;
      bus_if.rs1 = 5'd7; bus_if.rs2 = 5'd7; bus_if.rd = 5'd7;
      bus_if.alu_result = 32'hA5A5A5A5; bus_if.memtoreg = 1'b0;
      bus_if.regiwrite = 1'b1; bus_if.estado = 4'b0011; #1;
      checks++;
      if (bus_if.rdata1 !== 32'h0) begin
         errors++;
         $display("FAIL bypass_no_commit: got %h expected 0", bus_if.rdata1);
      end
      bus_if.estado = 4'b0110; #1;
`ifdef WRITE_BYPASS_EN
      exp = 32'hA5A5A5A5;
`else
      exp = 32'h0;
`endif
      checks++;
      if (bus_if.rdata1 !== exp || bus_if.rdata2 !== exp) begin
         errors++;
         $display("FAIL bypass_same_cycle: got %h %h expected %h",
                  bus_if.rdata1, bus_if.rdata2, exp);
      end
      step();
      bus_if.regiwrite = 1'b0; #1;
      checks++;
      if (bus_if.rdata1 !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL bypass_after: got %h expected %h", bus_if.rdata1, 32'hA5A5A5A5);
      end
   endtask

   task automatic test_snapshot();
      int beat;
      int done_at;
      for (int i = 1; i < NREGS; i++) write_reg(AW'(i), XLEN'(i * 3));
      bus_if.dbg_ready = 1'b1; bus_if.snap_req = 1'b1;
      step();
      bus_if.snap_req = 1'b0;
      beat = 0; done_at = -1;
      for (int cyc = 0; cyc < 100; cyc++) begin
         bus_if.snap_req = (cyc == 5);
         checks++;
         if (bus_if.snap_busy !== 1'b1) begin
            errors++;
            $display("FAIL snap_busy_scan: cyc %0d got %b expected 1", cyc, bus_if.snap_busy);
         end
         if (bus_if.dbg_valid === 1'b1) begin
            checks++;
            if (bus_if.dbg_idx !== AW'(beat) || bus_if.dbg_data !== XLEN'(beat * 3)) begin
               errors++;
               $display("FAIL snap_beat: got idx=%0d data=%h expected idx=%0d data=%h",
                        bus_if.dbg_idx, bus_if.dbg_data, beat, beat * 3);
            end
            beat++;
         end
         if (bus_if.dbg_done === 1'b1) begin
            done_at = cyc;
            break;
         end
         step();
      end
      bus_if.snap_req = 1'b0;
      checks++;
      if (beat != NREGS || done_at != NREGS) begin
         errors++;
         $display("FAIL snap_length: got beats=%0d done_at=%0d expected %0d %0d",
                  beat, done_at, NREGS, NREGS);
      end
      step();
      checks++;
      if (bus_if.dbg_done !== 1'b0 || bus_if.snap_busy !== 1'b0) begin
         errors++;
         $display("FAIL snap_done_pulse: got done=%b busy=%b expected 0 0",
                  bus_if.dbg_done, bus_if.snap_busy);
      end
      step();
      checks++;
      if (bus_if.dbg_valid !== 1'b0 || bus_if.snap_busy !== 1'b0) begin
         errors++;
         $display("FAIL snap_req_not_queued: got valid=%b busy=%b expected 0 0",
                  bus_if.dbg_valid, bus_if.snap_busy);
      end
   endtask

   task automatic test_backpressure();
      int              hold;
      int              exp_idx;
      logic [XLEN-1:0] exp_data;
      logic            done;
      hold = 0; done = 1'b0;
      bus_if.dbg_ready = 1'b1; bus_if.snap_req = 1'b1;
      step();
      bus_if.snap_req = 1'b0;
      exp_idx = 0; exp_data = model[0];
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         bus_if.regiwrite = 1'b0; bus_if.dbg_ready = 1'b1;
         bus_if.estado = 4'b0110; bus_if.memtoreg = 1'b0;
         if (bus_if.dbg_valid && bus_if.dbg_idx == 2 && hold < 4) begin
            bus_if.dbg_ready = 1'b0;
            if (hold == 0) begin
               bus_if.rd = 5'd2; bus_if.alu_result = 32'h55; bus_if.regiwrite = 1'b1;
            end
            hold++;
         end else if (bus_if.dbg_valid && bus_if.dbg_idx == 4) begin
            bus_if.rd = 5'd9; bus_if.alu_result = 32'h99; bus_if.regiwrite = 1'b1;
         end
         if (bus_if.dbg_valid === 1'b1) begin
            checks++;
            if (bus_if.dbg_idx !== AW'(exp_idx) || bus_if.dbg_data !== exp_data) begin
               errors++;
               $display("FAIL bp_beat: got idx=%0d data=%h expected idx=%0d data=%h",
                        bus_if.dbg_idx, bus_if.dbg_data, exp_idx, exp_data);
            end
            if (bus_if.dbg_idx == 2) begin
               checks++;
               if (bus_if.dbg_data !== 32'd6) begin
                  errors++;
                  $display("FAIL bp_held_old: got %h expected %h", bus_if.dbg_data, 32'd6);
               end
            end
            if (bus_if.dbg_idx == 9) begin
               checks++;
               if (bus_if.dbg_data !== 32'h99) begin
                  errors++;
                  $display("FAIL bp_live_x9: got %h expected %h", bus_if.dbg_data, 32'h99);
               end
            end
            if (bus_if.dbg_ready && exp_idx != NREGS - 1) begin
               exp_idx++;
               exp_data = model[exp_idx];
            end
         end
         if (bus_if.dbg_done === 1'b1) done = 1'b1;
         else step();
      end
      bus_if.regiwrite = 1'b0;
      checks++;
      if (!done || hold != 4) begin
         errors++;
         $display("FAIL bp_complete: got done=%b hold=%0d expected 1 4", done, hold);
      end
      bus_if.rs1 = 5'd2; #1;
      checks++;
      if (bus_if.rdata1 !== 32'h55) begin
         errors++;
         $display("FAIL bp_x2_committed: got %h expected %h", bus_if.rdata1, 32'h55);
      end
      step();
   endtask

   task automatic test_random_stream();
      int              exp_idx;
      logic [XLEN-1:0] exp_data;
      logic [XLEN-1:0] e1;
      logic [XLEN-1:0] e2;
      logic            done;
      done = 1'b0;
      bus_if.snap_req = 1'b1;
      step();
      bus_if.snap_req = 1'b0;
      exp_idx = 0; exp_data = model[0];
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         bus_if.snap_req   = ($urandom_range(0, 7) == 0);
         bus_if.dbg_ready  = ($urandom_range(0, 3) != 0);
         bus_if.regiwrite  = $urandom_range(0, 1);
         bus_if.estado     = ($urandom_range(0, 2) == 0) ? 4'($urandom) :
                             4'(6 + $urandom_range(0, 1));
         bus_if.memtoreg   = $urandom_range(0, 1);
         bus_if.rd         = AW'($urandom);
         bus_if.rs1        = ($urandom_range(0, 3) == 0) ? bus_if.rd : AW'($urandom);
         bus_if.rs2        = AW'($urandom);
         bus_if.alu_result = $urandom;
         bus_if.mem_rdata  = $urandom;
         #1;
         e1 = exp_read(bus_if.rs1);
         e2 = exp_read(bus_if.rs2);
         checks++;
         if (bus_if.rdata1 !== e1 || bus_if.rdata2 !== e2) begin
            errors++;
            $display("FAIL rnd_read: rs1=%0d rs2=%0d got %h %h expected %h %h",
                     bus_if.rs1, bus_if.rs2, bus_if.rdata1, bus_if.rdata2, e1, e2);
         end
         if (bus_if.dbg_valid === 1'b1) begin
            checks++;
            if (bus_if.dbg_idx !== AW'(exp_idx) || bus_if.dbg_data !== exp_data) begin
               errors++;
               $display("FAIL rnd_beat: got idx=%0d data=%h expected idx=%0d data=%h",
                        bus_if.dbg_idx, bus_if.dbg_data, exp_idx, exp_data);
            end
            if (bus_if.dbg_ready && exp_idx != NREGS - 1) begin
               exp_idx++;
               exp_data = model[exp_idx];
            end
         end
         if (bus_if.dbg_done === 1'b1) done = 1'b1;
         else step();
      end
      bus_if.regiwrite = 1'b0; bus_if.snap_req = 1'b0;
      checks++;
      if (!done || exp_idx != NREGS - 1) begin
         errors++;
         $display("FAIL rnd_complete: got done=%b last=%0d expected 1 %0d",
                  done, exp_idx, NREGS - 1);
      end
      step();
   endtask

   task automatic test_reset_mid();
      int bad;
      write_reg(5'd5, 32'hCAFE0001);
      bus_if.dbg_ready = 1'b0; bus_if.snap_req = 1'b1;
      step();
      bus_if.snap_req = 1'b0;
      step(); step();
      bus_if.rs1 = 5'd5;
      #2 rst = 1'b0;
      #1;
      checks++;
      if (bus_if.dbg_valid !== 1'b0 || bus_if.snap_busy !== 1'b0 ||
          bus_if.dbg_idx !== '0 || bus_if.dbg_data !== '0) begin
         errors++;
         $display("FAIL mid_reset_ctrl: got valid=%b busy=%b idx=%0d data=%h expected 0",
                  bus_if.dbg_valid, bus_if.snap_busy, bus_if.dbg_idx, bus_if.dbg_data);
      end
      bad = 0;
      for (int i = 0; i < NREGS; i++) begin
         bus_if.rs1 = AW'(i); #1;
         if (bus_if.rdata1 !== '0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL mid_reset_regs: got %0d nonzero registers expected 0", bad);
      end
      for (int i = 0; i < NREGS; i++) model[i] = '0;
      @(negedge clk);
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus_if.dbg_done !== 1'b0 || bus_if.snap_busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL mid_reset_no_done: got %0d cycles with done/busy expected 0", bad);
      end
   endtask

   initial begin
      for (int i = 0; i < NREGS; i++) model[i] = '0;
      bus_if.estado = '0; bus_if.rs1 = '0; bus_if.rs2 = '0; bus_if.rd = '0;
      bus_if.regiwrite = 1'b0; bus_if.memtoreg = 1'b0;
      bus_if.alu_result = '0; bus_if.mem_rdata = '0;
      bus_if.snap_req = 1'b0; bus_if.dbg_ready = 1'b0;
      test_reset();
      test_write_gating();
      test_x0();
      test_bypass();
      test_snapshot();
      test_backpressure();
      test_random_stream();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
